// File: rtl/ps2_pkg.sv
// Shared PS/2 definitions: receiver state encoding, frame constants and the
// scan codes consumed by key_decoder and ps2_status.
package ps2_pkg;

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    DATA   = 2'd1,
    PARITY = 2'd2,
    STOP   = 2'd3
  } rx_state_e;

  localparam int FRAME_DATA_BITS = 8;

  localparam logic START_LVL = 1'b0;
  localparam logic STOP_LVL  = 1'b1;

  localparam logic [7:0] SC_W     = 8'h1D;
  localparam logic [7:0] SC_A     = 8'h1C;
  localparam logic [7:0] SC_S     = 8'h1B;
  localparam logic [7:0] SC_D     = 8'h23;
  localparam logic [7:0] SC_SPACE = 8'h29;
  localparam logic [7:0] SC_R     = 8'h2D;
  localparam logic [7:0] SC_BREAK = 8'hF0;

  // Odd parity holds when data ones plus the parity bit give an odd count.
  function automatic logic odd_parity_ok(input logic [7:0] data, input logic par);
    return ^{data, par};
  endfunction

endpackage

// File: rtl/ps2_line_filter.sv
// Two-flop synchronizer with an optional FILTER_LEN-sample glitch filter and a
// one-cycle falling-edge pulse derived from the (filtered) level.
module ps2_line_filter #(
  parameter int FILTER_LEN = 8,
  parameter bit FILTER_EN  = 1'b1
) (
  input  logic clk,
  input  logic rst,
  input  logic raw,
  output logic level,
  output logic fall
);

  logic [1:0] sync_q;
  logic       lvl;
  logic       lvl_d;

  // Idle PS/2 lines are high, so the synchronizer comes out of reset high.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      sync_q <= 2'b11;
    end else begin
      sync_q <= {sync_q[0], raw};
    end
  end

  generate
    if (FILTER_EN) begin : g_filter
      localparam int CW = $clog2(FILTER_LEN + 1);
      localparam logic [CW-1:0] CNT_LAST = CW'(FILTER_LEN - 1);

      logic [CW-1:0] cnt;
      logic          filt;

      // cnt counts consecutive samples that disagree with the current level;
      // the level follows only once FILTER_LEN of them have been seen.
      always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
          cnt  <= '0;
          filt <= 1'b1;
        end else if (sync_q[1] == filt) begin
          cnt <= '0;
        end else if (cnt >= CNT_LAST) begin
          filt <= sync_q[1];
          cnt  <= '0;
        end else begin
          cnt <= cnt + 1'b1;
        end
      end

      assign lvl = filt;
    end else begin : g_bypass
      assign lvl = sync_q[1];
    end
  endgenerate

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      lvl_d <= 1'b1;
    end else begin
      lvl_d <= lvl;
    end
  end

  assign level = lvl;
  assign fall  = lvl_d & ~lvl;

endmodule

// File: rtl/ps2_rx.sv
// PS/2 device-to-host receiver: filters the keyboard clock and deframes 11-bit
// frames into scan_code/scan_ready. Define PS2_RX_PARITY_CHECK_EN to reject bad parity.
module ps2_rx #(
  parameter int FILTER_LEN  = 8,
  parameter int BIT_TIMEOUT = 10000
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       ps2_clk,
  input  logic       ps2_dat,
  output logic [7:0] scan_code,
  output logic       scan_ready,
  output logic       frame_err
);
  import ps2_pkg::*;

  localparam int TW = $clog2(BIT_TIMEOUT + 1);
  localparam int BW = $clog2(FRAME_DATA_BITS + 1);
  localparam int IW = $clog2(FRAME_DATA_BITS);
  localparam logic [TW-1:0] TO_LAST  = TW'(BIT_TIMEOUT - 1);
  localparam logic [TW-1:0] TO_MAX   = TW'(BIT_TIMEOUT);
  localparam logic [BW-1:0] BIT_LAST = BW'(FRAME_DATA_BITS - 1);

  logic clk_level_unused;
  logic clk_fall;
  logic dat_s;
  logic dat_fall_unused;

  ps2_line_filter #(
    .FILTER_LEN (FILTER_LEN),
    .FILTER_EN  (1'b1)
  ) u_clk_filter (
    .clk   (clk),
    .rst   (rst),
    .raw   (ps2_clk),
    .level (clk_level_unused),
    .fall  (clk_fall)
  );

  // Data only needs synchronizing: it is stable around the filtered clock fall.
  ps2_line_filter #(
    .FILTER_LEN (FILTER_LEN),
    .FILTER_EN  (1'b0)
  ) u_dat_sync (
    .clk   (clk),
    .rst   (rst),
    .raw   (ps2_dat),
    .level (dat_s),
    .fall  (dat_fall_unused)
  );

  rx_state_e         state, state_n;
  logic [BW-1:0]     bit_cnt, bit_cnt_n;
  logic [7:0]        shift, shift_n;
  logic              parity_bit, parity_n;
  logic [TW-1:0]     to_cnt, to_cnt_n;
  logic [7:0]        code_n;
  logic              ready_n;
  logic              err_n;
  logic              to_hit;
  logic              frame_ok;

`ifdef PS2_RX_PARITY_CHECK_EN
  assign frame_ok = (dat_s == STOP_LVL) && odd_parity_ok(shift, parity_bit);
`else
  logic parity_unused;
  assign parity_unused = parity_bit;
  assign frame_ok      = (dat_s == STOP_LVL);
`endif

  // A fall in the same cycle always wins over the timeout.
  assign to_hit = (state != IDLE) && !clk_fall && (to_cnt >= TO_LAST);

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state      <= IDLE;
      bit_cnt    <= '0;
      shift      <= '0;
      parity_bit <= 1'b0;
      to_cnt     <= '0;
      scan_code  <= 8'h00;
      scan_ready <= 1'b0;
      frame_err  <= 1'b0;
    end else begin
      state      <= state_n;
      bit_cnt    <= bit_cnt_n;
      shift      <= shift_n;
      parity_bit <= parity_n;
      to_cnt     <= to_cnt_n;
      scan_code  <= code_n;
      scan_ready <= ready_n;
      frame_err  <= err_n;
    end
  end

  always_comb begin
    state_n   = state;
    bit_cnt_n = bit_cnt;
    shift_n   = shift;
    parity_n  = parity_bit;
    to_cnt_n  = to_cnt;
    code_n    = scan_code;
    ready_n   = 1'b0;
    err_n     = 1'b0;

    if (state == IDLE || clk_fall) begin
      to_cnt_n = '0;
    end else if (to_cnt != TO_MAX) begin
      to_cnt_n = to_cnt + 1'b1;
    end

    if (clk_fall) begin
      case (state)
        IDLE: begin
          if (dat_s == START_LVL) begin
            state_n   = DATA;
            bit_cnt_n = '0;
            shift_n   = '0;
          end
        end
        DATA: begin
          shift_n[bit_cnt[IW-1:0]] = dat_s;
          bit_cnt_n                = bit_cnt + 1'b1;
          if (bit_cnt == BIT_LAST) begin
            state_n = PARITY;
          end
        end
        PARITY: begin
          parity_n = dat_s;
          state_n  = STOP;
        end
        STOP: begin
          state_n = IDLE;
          if (frame_ok) begin
            code_n  = shift;
            ready_n = 1'b1;
          end else begin
            err_n = 1'b1;
          end
        end
        default: state_n = IDLE;
      endcase
    end else if (to_hit) begin
      // Abandon the partial frame; the next start bit clears the shift register.
      state_n = IDLE;
      err_n   = 1'b1;
    end
  end

endmodule

// File: tb/tb_ps2_rx.sv
// Scoreboard bench for ps2_rx: directed PS/2 frames in, expected
// {timeout_kind, is_err, scan_code} events queued and checked by a monitor.
module tb_ps2_rx;
  import ps2_pkg::*;

  localparam int FL   = 4;
  localparam int BT   = 200;
  localparam int HALF = 20;

  logic       clk = 1'b0;
  logic       rst;
  logic       ps2_clk;
  logic       ps2_dat;
  logic [7:0] scan_code;
  logic       scan_ready;
  logic       frame_err;

  int checks = 0;
  int errors = 0;
  int cyc = 0;
  int last_fall_cyc = 0;
  logic [9:0] exp_q[$];
  logic [7:0] last_code;

  ps2_rx #(
    .FILTER_LEN  (FL),
    .BIT_TIMEOUT (BT)
  ) dut (
    .clk        (clk),
    .rst        (rst),
    .ps2_clk    (ps2_clk),
    .ps2_dat    (ps2_dat),
    .scan_code  (scan_code),
    .scan_ready (scan_ready),
    .frame_err  (frame_err)
  );

  // ---------------- clock / reset ----------------
  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  // ---------------- driver ----------------
  function automatic logic [10:0] make_frame(input logic [7:0] d, input logic p, input logic s);
    return {s, p, d, START_LVL};
  endfunction

  task automatic send_bits(input logic [10:0] frame, input int nbits, input int glitch_at);
    for (int i = 0; i < nbits; i++) begin
      @(negedge clk);
      ps2_dat = frame[i];
      if (i == glitch_at) begin
        repeat (6) @(negedge clk);
        ps2_clk = 1'b0;
        repeat (3) @(negedge clk);
        ps2_clk = 1'b1;
        repeat (HALF - 10) @(negedge clk);
      end else begin
        repeat (HALF - 1) @(negedge clk);
      end
      ps2_clk = 1'b0;
      last_fall_cyc = cyc;
      repeat (HALF) @(negedge clk);
      ps2_clk = 1'b1;
    end
    @(negedge clk);
    ps2_dat = 1'b1;
  endtask

  task automatic expect_evt(input logic timeout_kind, input logic is_err, input logic [7:0] code);
    exp_q.push_back({timeout_kind, is_err, code});
  endtask

  task automatic wait_drain(input string name);
    for (int i = 0; i < 2 * BT + 100 && exp_q.size() != 0; i++) @(negedge clk);
    checks++;
    if (exp_q.size() != 0) begin
      errors++;
      $display("FAIL %s: %0d expected events still pending, want 0", name, exp_q.size());
      exp_q.delete();
    end
  endtask

  task automatic check_reset_outputs(input string name);
    checks++;
    if (scan_code !== 8'h00 || scan_ready !== 1'b0 || frame_err !== 1'b0) begin
      errors++;
      $display("FAIL %s: got code=%02h ready=%0b err=%0b, want code=00 ready=0 err=0",
               name, scan_code, scan_ready, frame_err);
    end
  endtask

  // ---------------- monitor / scoreboard ----------------
  always @(negedge clk) begin
    logic [9:0] e;
    logic [8:0] act;
    int lat;
    int lo;
    if (!rst && (scan_ready || frame_err)) begin
      act = {frame_err, scan_code};
      lat = cyc - last_fall_cyc;
      checks++;
      if (scan_ready && frame_err) begin
        errors++;
        $display("FAIL exclusive: got ready=1 err=1 together, want only one");
      end
      checks++;
      if (exp_q.size() == 0) begin
        errors++;
        $display("FAIL unexpected: got err=%0b code=%02h, want no event", act[8], act[7:0]);
      end else begin
        e = exp_q.pop_front();
        if (act !== e[8:0]) begin
          errors++;
          $display("FAIL event: got err=%0b code=%02h, want err=%0b code=%02h",
                   act[8], act[7:0], e[8], e[7:0]);
        end
        checks++;
        lo = (e[9] ? BT : 0) + FL + 2;
        if (lat < lo || lat > lo + 2) begin
          errors++;
          $display("FAIL latency: got %0d cycles after last ps2_clk fall, want %0d..%0d",
                   lat, lo, lo + 2);
        end
      end
    end
  end

  // ---------------- watchdog ----------------
  initial begin
    repeat (60000) @(posedge clk);
    errors++;
    $display("FAIL watchdog: simulation exceeded 60000 cycles");
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $fatal(1, "watchdog");
  end

  // ---------------- stimulus ----------------
  initial begin
    rst     = 1'b1;
    ps2_clk = 1'b1;
    ps2_dat = 1'b1;
    repeat (3) @(negedge clk);
    check_reset_outputs("reset_state");
    rst = 1'b0;
    repeat (20) @(negedge clk);

    // W, correct parity
    expect_evt(1'b0, 1'b0, SC_W);
    send_bits(make_frame(SC_W, 1'b1, 1'b1), 11, -1);
    wait_drain("frame_1d");
    last_code = SC_W;

    // back-to-back break + space
    expect_evt(1'b0, 1'b0, SC_BREAK);
    expect_evt(1'b0, 1'b0, SC_SPACE);
    send_bits(make_frame(SC_BREAK, 1'b1, 1'b1), 11, -1);
    send_bits(make_frame(SC_SPACE, 1'b0, 1'b1), 11, -1);
    wait_drain("back_to_back");
    last_code = SC_SPACE;

    // A with wrong parity
`ifdef PS2_RX_PARITY_CHECK_EN
    expect_evt(1'b0, 1'b1, last_code);
`else
    expect_evt(1'b0, 1'b0, SC_A);
    last_code = SC_A;
`endif
    send_bits(make_frame(SC_A, 1'b1, 1'b1), 11, -1);
    wait_drain("bad_parity");

    // bad stop bit always rejected, scan_code held
    expect_evt(1'b0, 1'b1, last_code);
    send_bits(make_frame(SC_W, 1'b1, 1'b0), 11, -1);
    wait_drain("bad_stop");
    repeat (40) @(negedge clk);

    // 3-cycle clock glitch inside D frame
    expect_evt(1'b0, 1'b0, SC_D);
    send_bits(make_frame(SC_D, 1'b0, 1'b1), 11, 3);
    wait_drain("glitch");
    last_code = SC_D;

    // start + 4 data bits, then clock stays high -> timeout
    expect_evt(1'b1, 1'b1, last_code);
    send_bits(make_frame(SC_R, 1'b1, 1'b1), 5, -1);
    wait_drain("timeout");
    repeat (20) @(negedge clk);
    expect_evt(1'b0, 1'b0, SC_R);
    send_bits(make_frame(SC_R, 1'b1, 1'b1), 11, -1);
    wait_drain("after_timeout");

    // reset after start + 6 data bits of S
    send_bits(make_frame(SC_S, 1'b1, 1'b1), 7, -1);
    rst = 1'b1;
    repeat (2) @(negedge clk);
    check_reset_outputs("mid_frame_reset");
    rst = 1'b0;
    repeat (60) @(negedge clk);
    check_reset_outputs("after_reset_release");
    expect_evt(1'b0, 1'b0, SC_S);
    send_bits(make_frame(SC_S, 1'b1, 1'b1), 11, -1);
    wait_drain("after_reset_frame");

    repeat (50) @(negedge clk);
    checks++;
    if (exp_q.size() != 0) begin
      errors++;
      $display("FAIL final_queue: got %0d pending events, want 0", exp_q.size());
    end
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
